slave_link_rx: RTL
==================

// Module: slave_link_rx
// PURPOSE
//  Master-side receiver for the serial_data link driven by each SlaveFPGA. One instance per slave.
//  - Deserialises one frame per conversion: two AD7673 16-bit samples.
//  - Checks framing, plus parity when PARITY_CHECK_EN is defined.
//  - Presents each good frame as one 32-bit word on a valid/ready port to the USB packing stage.
//  - Flags a slave that fails to answer a start_adc request within a timeout.
// PARAMETERS
//  CLKS_PER_BIT    4      clk cycles per serial bit; minimum 2
//  TIMEOUT_CYCLES  1024   cycles after start_adc with no start bit before timeout_error sets
// PORTS
//  clk            in   1   system clock, shared with the slaves
//  reset          in   1   synchronous, active-high
//  start_adc      in   1   1-cycle pulse sent to the slave; arms the response timer
//  serial_in      in   1   line from the slave; idles high
//  clear_errors   in   1   1-cycle pulse; clears all sticky error flags
//  out_data       out  32  [31:16] = ADC1 sample, [15:0] = ADC2 sample
//  out_valid      out  1   out_data holds an unconsumed frame
//  out_ready      in   1   consumer accepts when out_valid && out_ready
//  frame_count    out  16  count of good frames received; wraps 0xFFFF -> 0
//  busy           out  1   receiver is not in IDLE
//  parity_error   out  1   sticky
//  framing_error  out  1   sticky
//  overflow       out  1   sticky
//  timeout_error  out  1   sticky
// BEHAVIOUR
//  - Reset values: every output is 0. FSM goes to IDLE, the timer disarms, any partial frame is discarded.
//  - Input register: serial_in is registered once. All decisions use the registered value (s_q).
//  - Frame format: start bit (0), then 32 data bits MSB first, then [parity bit], then stop bit (1).
//  - FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE. PARITY is present only with the macro.
//  - IDLE: s_q == 0 enters START and loads the bit counter with CLKS_PER_BIT/2.
//  - START: at mid-bit, if s_q == 1 the start was a glitch. Return to IDLE with no flag. Otherwise go to DATA.
//  - DATA, PARITY, STOP: each bit is sampled every CLKS_PER_BIT cycles at mid-bit. Data shifts in MSB first.
//  - STOP sample == 0: set framing_error, discard the frame, return to IDLE.
//    - IDLE does not re-arm until s_q == 1 has been seen for one cycle.
//  - Good frame: out_data and out_valid load on the cycle after the stop-bit sample; frame_count increments.
//  - Handshake:
//    - out_valid stays high and out_data stays stable until out_valid && out_ready.
//    - After acceptance, out_valid drops on the next cycle unless a new frame loads in that same cycle.
//  - Overflow: a good frame completes while out_valid && !out_ready.
//    - The new frame is dropped, the old data is kept, overflow sets, frame_count does not increment.
//    - If out_ready is high in that same cycle, the new frame loads normally and there is no overflow.
//  - Timeout:
//    - start_adc arms the timer and clears it to 0. start_adc while already armed restarts it from 0.
//    - The timer disarms when START is entered.
//    - If the timer reaches TIMEOUT_CYCLES-1 while armed: timeout_error sets and the timer disarms.
//  - clear_errors clears all sticky flags. If an error sets in the same cycle, the set wins.
//  - busy = (state != IDLE).
// CONFIGURATION
//  PARITY_CHECK_EN defined:
//    - Frame carries an even-parity bit after D0, so the 33 bits hold an even number of 1s.
//    - On mismatch: parity_error sets, the frame is discarded, STOP is still sampled before IDLE.
//  PARITY_CHECK_EN undefined:
//    - No parity bit; the frame is 34 bits.
//    - parity_error is tied to 0.
// TESTING (CLKS_PER_BIT=4, TIMEOUT_CYCLES=64, PARITY_CHECK_EN defined)
//  - Frame 0x1234ABCD, parity=1, stop=1, out_ready=1
//    -> out_valid pulses once with out_data=0x1234ABCD; frame_count=1; no flags.
//  - Frame 0x1234ABCD with parity=0
//    -> parity_error=1; out_valid stays 0; frame_count=0.
//  - Frame 0x00000000, parity=0, stop bit driven 0
//    -> framing_error=1; no out_valid; the next good frame is received normally.
//  - out_ready=0; frames 0x11110000 then 0x22220000
//    -> overflow=1; out_data=0x11110000; frame_count=1.
//  - start_adc pulse, serial_in held high
//    -> timeout_error=1 exactly 64 cycles later; a clear_errors pulse returns it to 0.
//  - Low glitch of 1 cycle on an idle line
//    -> busy high for 2 cycles, then IDLE; no flags.
//  - reset asserted mid-DATA
//    -> all outputs 0; the following frame 0xCAFEF00D is received intact.

Source files
------------

// File: rtl/slave_link_rx_if.sv
// Handshake/bus bundle between the serial_data receiver and its host logic.
interface slave_link_rx_if;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned COUNT_W = 16;

    logic               start_adc;
    logic               serial_in;
    logic               clear_errors;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic [COUNT_W-1:0] frame_count;
    logic               busy;
    logic               parity_error;
    logic               framing_error;
    logic               overflow;
    logic               timeout_error;

    // Host side: drives the line, the request pulse and the consumer ready.
    modport master (
        output start_adc, serial_in, clear_errors, out_ready,
        input  out_data, out_valid, frame_count, busy,
        input  parity_error, framing_error, overflow, timeout_error
    );

    // Receiver side.
    modport slave (
        input  start_adc, serial_in, clear_errors, out_ready,
        output out_data, out_valid, frame_count, busy,
        output parity_error, framing_error, overflow, timeout_error
    );
endinterface

// File: rtl/slave_link_rx.sv
// Master-side receiver for one slave's serial_data link: deserialises a
// 32-bit frame (two 16-bit samples), checks framing, presents good frames
// on a valid/ready port and flags slaves that do not answer start_adc.
// Optional feature macro: PARITY_CHECK_EN (adds an even-parity bit after D0).
module slave_link_rx #(
    parameter int unsigned CLKS_PER_BIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic           clk,
    input logic           reset,
    slave_link_rx_if.slave bus
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned COUNT_W = 16;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TMR_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                s_q, s_d;
    logic                rearm_q, rearm_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_bad_q, par_bad_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [COUNT_W-1:0]  frame_count_q, frame_count_d;
    logic                busy_q, busy_d;
    logic                framing_error_q, framing_error_d;
    logic                overflow_q, overflow_d;
    logic                timeout_error_q, timeout_error_d;
    logic                armed_q, armed_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
`ifdef PARITY_CHECK_EN
    logic                parity_error_q, parity_error_d;
`endif

    logic par_set, frm_set, ovf_set, tmo_set;
    logic frame_good, enter_start, sample;

    // Next-state, datapath, handshake, timer and sticky-flag logic.
    always_comb begin
        state_d         = state_q;
        s_d             = bus.serial_in;
        rearm_d         = rearm_q;
        cnt_d           = cnt_q;
        idx_d           = idx_q;
        shift_d         = shift_q;
        par_bad_d       = par_bad_q;
        out_data_d      = out_data_q;
        out_valid_d     = out_valid_q;
        frame_count_d   = frame_count_q;
        armed_d         = armed_q;
        timer_d         = timer_q;
        par_set         = 1'b0;
        frm_set         = 1'b0;
        ovf_set         = 1'b0;
        tmo_set         = 1'b0;
        frame_good      = 1'b0;
        enter_start     = 1'b0;
        sample          = (cnt_q == CNT_W'(1));

        // Bit-level receive FSM; every bit is taken at mid-bit.
        case (state_q)
            IDLE: begin
                if (!rearm_q && s_q) begin
                    rearm_d = 1'b1;
                end
                if (rearm_q && !s_q) begin
                    state_d     = START;
                    cnt_d       = CNT_W'(CLKS_PER_BIT / 2);
                    enter_start = 1'b1;
                end
            end
            START: begin
                if (sample) begin
                    if (s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        cnt_d     = CNT_W'(CLKS_PER_BIT);
                        idx_d     = '0;
                        par_bad_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d = {shift_q[DATA_W-2:0], s_q};
                    cnt_d   = CNT_W'(CLKS_PER_BIT);
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef PARITY_CHECK_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                if (sample) begin
                    cnt_d   = CNT_W'(CLKS_PER_BIT);
                    state_d = STOP;
                    if ((^shift_q) != s_q) begin
                        par_set   = 1'b1;
                        par_bad_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (sample) begin
                    state_d = IDLE;
                    if (!s_q) begin
                        frm_set = 1'b1;
                        rearm_d = 1'b0;
                    end else if (!par_bad_q) begin
                        frame_good = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Output handshake: acceptance frees the slot in the same cycle a new frame may load.
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (frame_good) begin
            if (!out_valid_q || bus.out_ready) begin
                out_data_d    = shift_q;
                out_valid_d   = 1'b1;
                frame_count_d = frame_count_q + COUNT_W'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end

        // Response timer: start_adc (re)arms, a start bit or expiry disarms.
        if (bus.start_adc) begin
            armed_d = 1'b1;
            timer_d = '0;
        end else if (armed_q) begin
            if (enter_start) begin
                armed_d = 1'b0;
            end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                tmo_set = 1'b1;
                armed_d = 1'b0;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end

        framing_error_d = (framing_error_q & ~bus.clear_errors) | frm_set;
        overflow_d      = (overflow_q      & ~bus.clear_errors) | ovf_set;
        timeout_error_d = (timeout_error_q & ~bus.clear_errors) | tmo_set;
`ifdef PARITY_CHECK_EN
        parity_error_d  = (parity_error_q  & ~bus.clear_errors) | par_set;
`endif
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset; line idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            s_q             <= 1'b1;
            rearm_q         <= 1'b0;
            cnt_q           <= '0;
            idx_q           <= '0;
            shift_q         <= '0;
            par_bad_q       <= 1'b0;
            out_data_q      <= '0;
            out_valid_q     <= 1'b0;
            frame_count_q   <= '0;
            busy_q          <= 1'b0;
            framing_error_q <= 1'b0;
            overflow_q      <= 1'b0;
            timeout_error_q <= 1'b0;
            armed_q         <= 1'b0;
            timer_q         <= '0;
`ifdef PARITY_CHECK_EN
            parity_error_q  <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            s_q             <= s_d;
            rearm_q         <= rearm_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            shift_q         <= shift_d;
            par_bad_q       <= par_bad_d;
            out_data_q      <= out_data_d;
            out_valid_q     <= out_valid_d;
            frame_count_q   <= frame_count_d;
            busy_q          <= busy_d;
            framing_error_q <= framing_error_d;
            overflow_q      <= overflow_d;
            timeout_error_q <= timeout_error_d;
            armed_q         <= armed_d;
            timer_q         <= timer_d;
`ifdef PARITY_CHECK_EN
            parity_error_q  <= parity_error_d;
`endif
        end
    end

    assign bus.out_data      = out_data_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.frame_count   = frame_count_q;
    assign bus.busy          = busy_q;
    assign bus.framing_error = framing_error_q;
    assign bus.overflow      = overflow_q;
    assign bus.timeout_error = timeout_error_q;
`ifdef PARITY_CHECK_EN
    assign bus.parity_error  = parity_error_q;
`else
    assign bus.parity_error  = 1'b0;
`endif
endmodule
